// File: rtl/mux16_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 16-way round-robin
// mux arbiter.
package mux16_arb_pkg;

  localparam int unsigned NREQ = 16;
  localparam int unsigned SELW = 4;

  typedef enum logic [0:0] {
    S_IDLE,
    S_GRANT
  } state_e;

  function automatic logic [NREQ-1:0] onehot16(input logic [SELW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin winner select: first set bit of eligible scanning from ptr upward,
// wrapping modulo 16.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [NREQ-1:0] rotated;
  logic [SELW-1:0] offset;

  // rotated[0] corresponds to requester ptr, so the lowest set bit is the winner
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NREQ; i++) begin
      rotated[i] = eligible[SELW'(i) + ptr];
    end
  end

  always_comb begin
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = SELW'(i);
      end
    end
  end

  assign any = |eligible;
  assign idx = offset + ptr;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin sequencer driving the 16:1 mux select; holds each grant for BURST beats
// and hands beats downstream over valid/ready.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int unsigned BURST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            out_ready,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            out_valid,
  output logic            last,
  output logic [NREQ-1:0] ack
);

  localparam int unsigned CNTW = $clog2(BURST) + 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] eligible;
  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] win_idx;
  logic            win_any;
  logic            xfer;
  logic            last_beat;
  logic            grant_end;

  assign eligible = req & mask;
  // While granting, the only arbitration that matters happens at grant end, which
  // must already see the rotated pointer.
  assign pick_ptr = (state_q == S_GRANT) ? sel_q + 4'd1 : ptr_q;

  rr_pick16 u_pick (
    .eligible (eligible),
    .ptr      (pick_ptr),
    .any      (win_any),
    .idx      (win_idx)
  );

  assign xfer      = valid_q & out_ready;
  assign last_beat = valid_q & (cnt_q == LAST_BEAT);
  assign grant_end = (xfer & last_beat) | (~req[sel_q] & ~xfer);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_GRANT;
          sel_d   = win_idx;
          gnt_d   = onehot16(win_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (xfer && !last_beat) begin
          cnt_d = cnt_q + CNTW'(1);
        end
        if (grant_end) begin
          ptr_d = sel_q + 4'd1;
          cnt_d = '0;
          if (win_any) begin
            sel_d   = win_idx;
            gnt_d   = onehot16(win_idx);
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            sel_d   = '0;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign last      = last_beat;
  assign ack       = gnt_q & {NREQ{xfer}};

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: BURST=1 and BURST=4 instances share stimulus and are
// each tracked by a round-robin reference model feeding a beat scoreboard.
module tb_mux16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, mask;
  logic        out_ready;

  logic [3:0]  sel_a, sel_b;
  logic [15:0] gnt_a, gnt_b, ack_a, ack_b;
  logic        vld_a, vld_b, last_a, last_b;

  mux16_rr_arbiter #(.BURST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .sel(sel_a), .gnt(gnt_a), .out_valid(vld_a), .last(last_a), .ack(ack_a)
  );

  mux16_rr_arbiter #(.BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .sel(sel_b), .gnt(gnt_b), .out_valid(vld_b), .last(last_b), .ack(ack_b)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic       last;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];

  // Model: whether a grant is open, who owns it, beats already accepted, scan start.
  bit m_valid[2];
  int m_owner[2];
  int m_beats[2];
  int m_ptr[2];

  function automatic int burst_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int pick(logic [15:0] elig, int start);
    for (int n = 0; n < 16; n++) begin
      if (elig[(start + n) % 16]) return (start + n) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_owner[k] = 0; m_beats[k] = 0; m_ptr[k] = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step(int k);
    logic [15:0] elig;
    int          w;
    bit          is_last, ended;
    elig = req & mask;
    if (!m_valid[k]) begin
      w = pick(elig, m_ptr[k]);
      if (w >= 0) begin
        m_valid[k] = 1; m_owner[k] = w; m_beats[k] = 0;
      end
    end else begin
      is_last = (m_beats[k] == burst_of(k) - 1);
      ended   = (out_ready && is_last) || (!req[m_owner[k]] && !out_ready);
      if (out_ready && !is_last) m_beats[k]++;
      if (ended) begin
        m_ptr[k] = (m_owner[k] + 1) % 16;
        w = pick(elig, m_ptr[k]);
        m_beats[k] = 0;
        if (w >= 0) m_owner[k] = w;
        else begin
          m_valid[k] = 0; m_owner[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [37:0] expected_vec(int k);
    logic [15:0] g;
    logic        l;
    g = m_valid[k] ? (16'd1 << m_owner[k]) : 16'd0;
    l = m_valid[k] && (m_beats[k] == burst_of(k) - 1);
    return {m_valid[k], 4'(m_owner[k]), g, l, (m_valid[k] && out_ready) ? g : 16'd0};
  endfunction

  function automatic logic [37:0] actual_vec(int k);
    if (k == 0) return {vld_a, sel_a, gnt_a, last_a, ack_a};
    return {vld_b, sel_b, gnt_b, last_b, ack_b};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge from that cycle's inputs, then queues expected beats.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        model_step(0);
        model_step(1);
      end
      #2;
      if (rst_n && out_ready) begin
        if (m_valid[0]) q_a.push_back('{sel: 4'(m_owner[0]), last: m_beats[0] == 0});
        if (m_valid[1]) q_b.push_back('{sel: 4'(m_owner[1]), last: m_beats[1] == 3});
      end
    end
  end

  // Monitor: per-cycle output state plus scoreboard pop on every accepted beat.
  initial begin
    beat_t got, want;
    forever begin
      @(negedge clk);
      check("outs_b1", 64'(actual_vec(0)), 64'(expected_vec(0)));
      check("outs_b4", 64'(actual_vec(1)), 64'(expected_vec(1)));
      if (vld_a && out_ready) begin
        got = '{sel: sel_a, last: last_a};
        if (q_a.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL beat_b1 actual=sel%0d required=no_beat at %0t", sel_a, $time);
        end else begin
          want = q_a.pop_front();
          check("beat_b1", 64'(got), 64'(want));
        end
      end
      if (vld_b && out_ready) begin
        got = '{sel: sel_b, last: last_b};
        if (q_b.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL beat_b4 actual=sel%0d required=no_beat at %0t", sel_b, $time);
        end else begin
          want = q_b.pop_front();
          check("beat_b4", 64'(got), 64'(want));
        end
      end
    end
  end

  task automatic cyc(logic [15:0] r, logic [15:0] m, logic rdy);
    @(posedge clk);
    #1;
    req = r; mask = m; out_ready = rdy;
  endtask

  task automatic go_idle();
    repeat (12) cyc(16'h0000, 16'hFFFF, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req = 16'hFFFF; mask = 16'hFFFF; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Rotation across 0, 2, 15.
    repeat (12) cyc(16'h8005, 16'hFFFF, 1'b1);
    go_idle();

    // Single requester with alternating backpressure.
    for (int i = 0; i < 20; i++) cyc(16'h0010, 16'hFFFF, i[0] == 1'b0);
    go_idle();

    // Masked requester, then unmasked mid-burst.
    repeat (3) cyc(16'h0003, 16'h0002, 1'b1);
    repeat (8) cyc(16'h0003, 16'h0003, 1'b1);
    go_idle();

    // Abort: grantee 7 drops req under backpressure after two beats.
    cyc(16'h0080, 16'hFFFF, 1'b0);
    repeat (2) cyc(16'h0080, 16'hFFFF, 1'b1);
    cyc(16'h0080, 16'hFFFF, 1'b0);
    cyc(16'h0100, 16'hFFFF, 1'b0);
    repeat (3) cyc(16'h0000, 16'hFFFF, 1'b0);
    go_idle();

    // Async reset mid-burst on grantee 9.
    cyc(16'h0200, 16'hFFFF, 1'b0);
    repeat (2) cyc(16'h0200, 16'hFFFF, 1'b1);
    cyc(16'h0200, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_clr_valid", 64'(vld_b), 64'(0));
    check("async_clr_gnt", 64'(gnt_b), 64'(0));
    check("async_clr_ack", 64'(ack_b), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; req = 16'h0300; mask = 16'hFFFF; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_sel", 64'(sel_b), 64'(8));
    check("post_reset_gnt", 64'(gnt_b), 64'(16'h0100));
    repeat (6) cyc(16'h0300, 16'hFFFF, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(16'($urandom) & 16'($urandom), 16'($urandom) | 16'($urandom),
          $urandom_range(0, 3) != 0);
    end
    go_idle();

    @(negedge clk);
    check("sb_drain", 64'(q_a.size() + q_b.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
